des_key_schedule: RTL

Sequential DES key-schedule generator that sits directly upstream of the f-block round datapath. It accepts a 64-bit key, applies PC-1 and the per-round rotations, and presents one 48-bit round key (PC-2 output) per accepted handshake. Keys come out in K1..K16 order for encryption and K16..K1 for decryption.

---
 rtl/des_pkg.sv | 24 ++
 rtl/pc2.sv | 13 +
 rtl/des_key_schedule.sv | 108 ++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule permutation tables, shift mask and state type
package des_pkg;

  // Entries are DES bit numbers (1 = MSB) of the source vector.
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit i set: round i+1 rotates by one position instead of two.
  localparam logic [15:0] SHIFT_ONE = 16'b1000_0001_0000_0011;

  typedef enum logic {IDLE, RUN} ks_state_e;

endpackage

// File: rtl/pc2.sv
// rtl/pc2.sv - PC-2 compression permutation, 56-bit C||D to 48-bit round key
module pc2 (
  input  logic [55:0] cd,
  output logic [47:0] k
);
  import des_pkg::*;

  // DES bit n of cd lives at cd[56-n]; output bit j at k[48-j].
  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign k[47-i] = cd[56-PC2[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES round-key generator with ready/valid output
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        k_ready,
  output logic        busy,
  output logic        k_valid,
  output logic [47:0] r_key,
  output logic [3:0]  round,
  output logic        last
);

  ks_state_e   state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic [55:0] pc1_key;
  logic        one_step;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[55-i] = key[64-PC1[i]];
  end

  function automatic logic [27:0] rotate28(input logic [27:0] x, input logic right,
                                           input logic one);
    case ({right, one})
      2'b00:   rotate28 = {x[25:0], x[27:26]};
      2'b01:   rotate28 = {x[26:0], x[27]};
      2'b10:   rotate28 = {x[1:0], x[27:2]};
      default: rotate28 = {x[0], x[27:1]};
    endcase
  endfunction

  // Decrypt undoes the rotation of the round just emitted; encrypt applies the next one.
  assign one_step = dec_q ? SHIFT_ONE[4'd15 - round_q] : SHIFT_ONE[round_q + 4'd1];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dec_d   = decrypt;
          round_d = 4'd0;
          if (decrypt) begin
            c_d = pc1_key[55:28];
            d_d = pc1_key[27:0];
          end else begin
            c_d = rotate28(pc1_key[55:28], 1'b0, 1'b1);
            d_d = rotate28(pc1_key[27:0], 1'b0, 1'b1);
          end
        end
      end
      RUN: begin
        if (k_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            c_d     = 28'h0;
            d_d     = 28'h0;
            round_d = 4'd0;
            dec_d   = 1'b0;
          end else begin
            c_d     = rotate28(c_q, dec_q, one_step);
            d_d     = rotate28(d_q, dec_q, one_step);
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= 28'h0;
      d_q     <= 28'h0;
      round_q <= 4'd0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign k_valid = busy;
  assign round   = round_q;
  assign last    = busy && (round_q == 4'd15);

  pc2 u_pc2 (
    .cd ({c_q, d_q}),
    .k  (r_key)
  );

endmodule
